// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding, default widths and idle output levels for the SPI clock sequencer
package spi_pkg;

   localparam int CNT_W_DEF  = 16;
   localparam int BITS_W_DEF = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_RUN   = 3'd2,
      ST_HOLD  = 3'd3,
      ST_DONE  = 3'd4
   } spi_state_e;

   localparam logic IDLE_CS_N = 1'b1;
   localparam logic IDLE_BUSY = 1'b0;
   localparam logic IDLE_DONE = 1'b0;
   localparam logic IDLE_STB  = 1'b0;
   localparam logic RST_SCLK  = 1'b0;

endpackage

// File: rtl/spi_sclk_ctrl_if.sv
// rtl/spi_sclk_ctrl_if.sv - command/status bundle between SPI register logic and the SCLK sequencer
interface spi_sclk_ctrl_if #(
   parameter int CNT_W  = 16,
   parameter int BITS_W = 6
);
   logic              start;
   logic [CNT_W-1:0]  div;
   logic [BITS_W-1:0] nbits;
   logic              cpol;
   logic              abort;
   logic              sclk;
   logic              cs_n;
   logic              busy;
   logic              lead_stb;
   logic              trail_stb;
   logic              done;

   modport master (
      output start, div, nbits, cpol, abort,
      input  sclk, cs_n, busy, lead_stb, trail_stb, done
   );

   modport slave (
      input  start, div, nbits, cpol, abort,
      output sclk, cs_n, busy, lead_stb, trail_stb, done
   );
endinterface

// File: rtl/sclk_tick_gen.sv
// rtl/sclk_tick_gen.sv - half-period counter, ticks for one cycle every div+1 enabled cycles
module sclk_tick_gen #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_div,
   output logic             o_tick
);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_term;

   assign w_at_term = (r_cnt == i_div);
   assign o_tick    = i_en & w_at_term;

   // Wrapping at the terminal count, not on overflow, keeps div = all-ones safe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         if (w_at_term) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/spi_sclk_ctrl.sv
// rtl/spi_sclk_ctrl.sv - sequences a bounded, gated SCLK burst with chip-select and edge strobes
module spi_sclk_ctrl
   import spi_pkg::*;
#(
   parameter int CNT_W  = CNT_W_DEF,
   parameter int BITS_W = BITS_W_DEF
) (
   input logic            clk,
   input logic            rst,
   spi_sclk_ctrl_if.slave bus
);

   spi_state_e        r_state;
   spi_state_e        w_state_nxt;
   logic [CNT_W-1:0]  r_div;
   logic [CNT_W-1:0]  w_div_nxt;
   logic [BITS_W-1:0] r_nbits;
   logic [BITS_W-1:0] w_nbits_nxt;
   logic [BITS_W-1:0] r_bitcnt;
   logic [BITS_W-1:0] w_bitcnt_nxt;
   logic [BITS_W-1:0] w_bit_inc;
   logic              r_cpol;
   logic              w_cpol_nxt;
   logic              r_sclk;
   logic              w_sclk_nxt;
   logic              r_cs_n;
   logic              r_busy;
   logic              r_lead_stb;
   logic              w_lead_nxt;
   logic              r_trail_stb;
   logic              w_trail_nxt;
   logic              r_done;
   logic              w_active;
   logic              w_active_nxt;
   logic              w_tick;
   logic              w_clr;

   assign w_active     = (r_state == ST_SETUP) || (r_state == ST_RUN) || (r_state == ST_HOLD);
   assign w_active_nxt = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_RUN) ||
                         (w_state_nxt == ST_HOLD);
   assign w_clr        = (w_state_nxt != r_state);
   assign w_bit_inc    = r_bitcnt + BITS_W'(1);

   sclk_tick_gen #(
      .CNT_W (CNT_W)
   ) u_tick (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_clr),
      .i_en   (w_active),
      .i_div  (r_div),
      .o_tick (w_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_div       <= '0;
         r_nbits     <= '0;
         r_cpol      <= RST_SCLK;
         r_bitcnt    <= '0;
         r_sclk      <= RST_SCLK;
         r_cs_n      <= IDLE_CS_N;
         r_busy      <= IDLE_BUSY;
         r_lead_stb  <= IDLE_STB;
         r_trail_stb <= IDLE_STB;
         r_done      <= IDLE_DONE;
      end else begin
         r_state     <= w_state_nxt;
         r_div       <= w_div_nxt;
         r_nbits     <= w_nbits_nxt;
         r_cpol      <= w_cpol_nxt;
         r_bitcnt    <= w_bitcnt_nxt;
         r_sclk      <= w_sclk_nxt;
         r_cs_n      <= ~w_active_nxt;
         r_busy      <= w_active_nxt;
         r_lead_stb  <= w_lead_nxt;
         r_trail_stb <= w_trail_nxt;
         r_done      <= (w_state_nxt == ST_DONE);
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_div_nxt    = r_div;
      w_nbits_nxt  = r_nbits;
      w_cpol_nxt   = r_cpol;
      w_bitcnt_nxt = r_bitcnt;
      w_sclk_nxt   = r_sclk;
      w_lead_nxt   = IDLE_STB;
      w_trail_nxt  = IDLE_STB;

      case (r_state)
         ST_IDLE: begin
            w_sclk_nxt = r_cpol;
            if (bus.start) begin
               w_div_nxt    = bus.div;
               w_nbits_nxt  = bus.nbits;
               w_cpol_nxt   = bus.cpol;
               w_sclk_nxt   = bus.cpol;
               w_bitcnt_nxt = '0;
               w_state_nxt  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (bus.abort) begin
               w_sclk_nxt  = r_cpol;
               w_state_nxt = ST_IDLE;
            end else if (w_tick) begin
               // The end of setup is itself the first leading edge.
               if (r_nbits != '0) begin
                  w_sclk_nxt  = ~r_sclk;
                  w_lead_nxt  = 1'b1;
                  w_state_nxt = ST_RUN;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (bus.abort) begin
               w_sclk_nxt  = r_cpol;
               w_state_nxt = ST_IDLE;
            end else if (w_tick) begin
               w_sclk_nxt = ~r_sclk;
               // SCLK away from its idle level means the next toggle is trailing.
               if (r_sclk != r_cpol) begin
                  w_trail_nxt  = 1'b1;
                  w_bitcnt_nxt = w_bit_inc;
                  if (w_bit_inc == r_nbits) begin
                     w_state_nxt = ST_HOLD;
                  end
               end else begin
                  w_lead_nxt = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (bus.abort) begin
               w_sclk_nxt  = r_cpol;
               w_state_nxt = ST_IDLE;
            end else if (w_tick) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_sclk_nxt  = r_cpol;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.sclk      = r_sclk;
   assign bus.cs_n      = r_cs_n;
   assign bus.busy      = r_busy;
   assign bus.lead_stb  = r_lead_stb;
   assign bus.trail_stb = r_trail_stb;
   assign bus.done      = r_done;

endmodule

// File: doc/spi_sclk_ctrl.md
Name: spi_sclk_ctrl

Overview:
- Sequencer for the SPI serial clock. Turns a system-clock counter into a bounded SCLK burst.
- Drives chip-select, SCLK and per-edge strobes for one transfer of N bits, with a start/busy/done handshake.
- Sits between the SPI register/command logic and the shift-register datapath.
- Replaces the free-running divider for SPI use with a programmable, gated, countable clock.

Parameters:
- CNT_W, 16, width of the half-period divisor.
- BITS_W, 6, width of the bit-count field (max 63 bits per transfer).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a transfer; accepted only in IDLE.
- div  in  CNT_W  half-period = div+1 clk cycles; sampled at accept.
- nbits  in  BITS_W  SCLK cycles per transfer; sampled at accept.
- cpol  in  1  SCLK idle level; sampled at accept.
- abort  in  1  terminate the current transfer.
- sclk  out  1  serial clock.
- cs_n  out  1  chip select, active low.
- busy  out  1  high from SETUP through HOLD.
- lead_stb  out  1  one-cycle pulse, in the same cycle as each leading SCLK edge.
- trail_stb  out  1  one-cycle pulse, in the same cycle as each trailing SCLK edge.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, any time): state=IDLE, sclk=0, cs_n=1, busy=0, done=0, lead_stb=0, trail_stb=0, all counters=0.
- All outputs are registered.
- D and N denote the latched div and nbits; H=D+1 is the half-period in clk cycles.
- FSM states: IDLE, SETUP, RUN, HOLD, DONE.
- IDLE:
  - sclk = latched cpol; cs_n=1; busy=0.
  - start=1 sampled at edge 0 latches div/nbits/cpol and moves to SETUP.
  - From cycle 1: cs_n=0, busy=1, sclk=new cpol.
- SETUP: lasts H cycles. At terminal tick, go to RUN if N>0, else DONE.
- RUN:
  - Every H cycles sclk toggles.
  - Odd toggles are leading edges and pulse lead_stb.
  - Even toggles are trailing edges, pulse trail_stb and increment the bit counter.
  - The trailing edge with bit counter = N moves to HOLD; sclk is then back at cpol.
- HOLD: lasts H cycles with cs_n=0. Its terminal tick goes to DONE.
- DONE: one cycle. done=1, busy=0, cs_n=1. Next state is IDLE.
- Timing, relative to start accept at edge 0:
  - SCLK edge k (k=1..2N) appears at cycle 1+k·H.
  - done and cs_n deassertion appear at cycle 1+(2N+1)·H.
  - N=0 gives done at cycle 1+H, with no SCLK edges.
- start is ignored outside IDLE, including the DONE cycle. Back-to-back transfers are therefore at least one IDLE cycle apart.
- abort=1 in SETUP/RUN/HOLD:
  - Next cycle: state IDLE, sclk=cpol, cs_n=1, busy=0, strobes 0, done NOT pulsed.
  - abort in IDLE or DONE has no effect.
- If abort and start are both high in IDLE, start wins.
- Changes on div/nbits/cpol mid-transfer have no effect until the next accept.
- Half-period counter: counts 0..D and ticks at D, then wraps to 0.
  - Cleared on every state entry.
  - D=0 ticks every cycle; D=2^CNT_W−1 must wrap with no overflow.

Decomposition:
- Package spi_pkg holds:
  - the state enum (IDLE, SETUP, RUN, HOLD, DONE);
  - CNT_W and BITS_W defaults;
  - the localparams for the IDLE output values.
- One sub-module, sclk_tick_gen: a half-period counter with inputs clr, en and div, and a one-cycle tick output. It is reused by any later SPI timing blocks.

Test Plan:
- Reset with a transfer in flight: assert rst at RUN mid-burst → same cycle sclk=0, cs_n=1, busy=0, done=0. After release, start works normally.
- div=1, nbits=2, cpol=0, start at cycle 0 → sclk rises at 3 and 7, falls at 5 and 9 → lead_stb at 3 and 7, trail_stb at 5 and 9, done at 11, busy high for cycles 1–10.
- div=0, nbits=1, cpol=1 → sclk falls at 2 and rises at 3 → done at 4, cs_n low for cycles 1–3.
- nbits=0, div=3 → no sclk edges and no strobes → done at cycle 5.
- abort at the 3rd SCLK edge of an 8-bit transfer → next cycle cs_n=1, sclk=cpol, busy=0, no done pulse. A start 2 cycles later is accepted.
- start held high through DONE, plus div changed mid-transfer → exactly one transfer completes with the original timing, then a second transfer starts from IDLE using the new div.
